// File: rtl/instr_encoder.sv
// Instruction encoder: turns symbolic requests into 32-bit instruction words,
// buffers them in a small FIFO and streams them into imem at consecutive addresses.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [25:0]       req_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              imem_we,
    input  logic              imem_wready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal,
    output logic [15:0]       words_wr,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count, count_nxt;
    logic [ADDR_W-1:0] wptr;
    logic              accept, illegal, push, pop, full;
    logic [31:0]       word;

    function automatic logic [5:0] opcode_of(input logic [3:0] op);
        case (op)
            4'd0:    opcode_of = 6'b000000;
            4'd1:    opcode_of = 6'b100000;
            4'd2:    opcode_of = 6'b000010;
            4'd3:    opcode_of = 6'b000011;
            4'd4:    opcode_of = 6'b000100;
            4'd5:    opcode_of = 6'b000101;
            4'd6:    opcode_of = 6'b001000;
            4'd7:    opcode_of = 6'b010000;
            4'd8:    opcode_of = 6'b001001;
            4'd9:    opcode_of = 6'b010001;
            4'd10:   opcode_of = 6'b000111;
            4'd11:   opcode_of = 6'b100011;
            4'd12:   opcode_of = 6'b100111;
            4'd13:   opcode_of = 6'b111000;
            4'd14:   opcode_of = 6'b111001;
            default: opcode_of = 6'b000000;
        endcase
    endfunction

    // Fields not belonging to the selected format are forced to zero.
    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [5:0] funct, input logic [25:0] imm);
        logic [5:0] opc;
        opc = opcode_of(op);
        case (op)
            4'd0:        encode = {6'b000000, rs, rt, rd, 5'b00000, funct};
            4'd1:        encode = {opc, rs, rt, 16'h0000};
            4'd13, 4'd14: encode = {opc, imm};
            default:     encode = {opc, rs, rt, imm[15:0]};
        endcase
    endfunction

    assign word      = encode(req_op, req_rs, req_rt, req_rd, req_funct, req_imm);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign illegal   = (req_op == 4'd15);
    assign push      = accept && !illegal;
    assign pop       = (state == WRITE) && imem_wready && (count != '0);
    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign busy      = (count != '0) || (state == WRITE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            err_illegal <= accept && illegal;
        end
    end

    // base_load can only coincide with idle, so it never races a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            words_wr <= '0;
        end else if (base_load && !busy) begin
            wptr     <= base_addr & ~ADDR_W'(3);
            words_wr <= '0;
        end else if (pop) begin
            wptr <= wptr + ADDR_W'(4);
            if (words_wr != 16'hFFFF)
                words_wr <= words_wr + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A push into an empty FIFO enters WRITE on the same edge for one-cycle latency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if ((count != '0) || push) state_nxt = WRITE;
            WRITE:   if (count_nxt == '0)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_we    = (state == WRITE);
        imem_addr  = wptr;
        imem_wdata = imem_we ? mem[rd_ptr] : 32'h0;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO backpressure, base_load,
// illegal ops and asynchronous reset mid-write.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [5:0]  req_funct;
    logic [25:0] req_imm;
    logic        base_load;
    logic [15:0] base_addr;
    logic        imem_we;
    logic        imem_wready;
    logic [15:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err_illegal;
    logic [15:0] words_wr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm),
        .base_load(base_load), .base_addr(base_addr),
        .imem_we(imem_we), .imem_wready(imem_wready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .err_illegal(err_illegal), .words_wr(words_wr), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] funct, input logic [25:0] imm);
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_funct = funct; req_imm = imm;
        req_valid = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".we"},    {31'b0, imem_we},     32'h0);
        chk({tag, ".ready"}, {31'b0, req_ready},   32'h1);
        chk({tag, ".busy"},  {31'b0, busy},        32'h0);
        chk({tag, ".err"},   {31'b0, err_illegal}, 32'h0);
        chk({tag, ".addr"},  {16'b0, imem_addr},   32'h0);
        chk({tag, ".wdata"}, imem_wdata,           32'h0);
        chk({tag, ".words"}, {16'b0, words_wr},    32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0;
        req_rd = '0; req_funct = '0; req_imm = '0; base_load = 1'b0; base_addr = '0;
        imem_wready = 1'b0;
        tick(); tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // T1: ADDI, then MOVE whose immediate must be ignored
        imem_wready = 1'b1;
        set_req(4'd2, 5'd1, 5'd2, 5'd31, 6'h3F, 26'h3FF0005);
        tick(); req_valid = 1'b0;
        chk("t1.we",    {31'b0, imem_we}, 32'h1);
        chk("t1.addr",  {16'b0, imem_addr}, 32'h0);
        chk("t1.wdata", imem_wdata, 32'h08220005);
        tick();
        chk("t1.we_off", {31'b0, imem_we}, 32'h0);
        chk("t1.words",  {16'b0, words_wr}, 32'h1);
        chk("t1.busy",   {31'b0, busy}, 32'h0);
        set_req(4'd1, 5'd4, 5'd5, 5'd7, 6'h11, 26'h000ABCD);
        tick(); req_valid = 1'b0;
        chk("move.addr",  {16'b0, imem_addr}, 32'h4);
        chk("move.wdata", imem_wdata, 32'h80850000);
        tick();
        chk("move.words", {16'b0, words_wr}, 32'h2);

        // T2: base_load 0 while idle, then RTYPE and J back to back
        base_load = 1'b1; base_addr = 16'h0000;
        tick(); base_load = 1'b0;
        chk("t2.base_addr",  {16'b0, imem_addr}, 32'h0);
        chk("t2.base_words", {16'b0, words_wr}, 32'h0);
        set_req(4'd0, 5'd3, 5'd4, 5'd5, 6'h20, 26'h3FFFFFF);
        tick();
        chk("t2.r_addr",  {16'b0, imem_addr}, 32'h0);
        chk("t2.r_wdata", imem_wdata, 32'h00642820);
        set_req(4'd13, 5'd9, 5'd9, 5'd9, 6'h3F, 26'h0000100);
        tick(); req_valid = 1'b0;
        chk("t2.j_we",    {31'b0, imem_we}, 32'h1);
        chk("t2.j_addr",  {16'b0, imem_addr}, 32'h4);
        chk("t2.j_wdata", imem_wdata, 32'hE0000100);
        tick();
        chk("t2.we_off", {31'b0, imem_we}, 32'h0);
        chk("t2.words",  {16'b0, words_wr}, 32'h2);

        // T3: backpressure, FIFO fills after four accepts
        base_load = 1'b1; base_addr = 16'h0000;
        tick(); base_load = 1'b0;
        imem_wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(4'd2, 5'd1, 5'd2, 5'd0, 6'h0, 26'(16'h0010 + k));
            chk($sformatf("t3.ready%0d", k), {31'b0, req_ready}, (k < 4) ? 32'h1 : 32'h0);
            tick();
            chk($sformatf("t3.hold_addr%0d", k), {16'b0, imem_addr}, 32'h0);
            chk($sformatf("t3.hold_data%0d", k), imem_wdata, 32'h08220010);
        end
        chk("t3.full", {31'b0, req_ready}, 32'h0);
        imem_wready = 1'b1;
        tick();
        chk("t3.ready_after_pop", {31'b0, req_ready}, 32'h1);
        chk("t3.w1_addr", {16'b0, imem_addr}, 32'h4);
        chk("t3.w1_data", imem_wdata, 32'h08220011);
        tick(); req_valid = 1'b0;
        chk("t3.w2_addr", {16'b0, imem_addr}, 32'h8);
        chk("t3.w2_data", imem_wdata, 32'h08220012);
        tick();
        chk("t3.w3_addr", {16'b0, imem_addr}, 32'hC);
        chk("t3.w3_data", imem_wdata, 32'h08220013);
        tick();
        chk("t3.w4_we",   {31'b0, imem_we}, 32'h1);
        chk("t3.w4_addr", {16'b0, imem_addr}, 32'h10);
        chk("t3.w4_data", imem_wdata, 32'h08220014);
        tick();
        chk("t3.we_off", {31'b0, imem_we}, 32'h0);
        chk("t3.words",  {16'b0, words_wr}, 32'h5);

        // T4: illegal op
        set_req(4'd15, 5'd1, 5'd1, 5'd1, 6'h1, 26'h1);
        tick(); req_valid = 1'b0;
        chk("t4.err",  {31'b0, err_illegal}, 32'h1);
        chk("t4.we",   {31'b0, imem_we}, 32'h0);
        chk("t4.busy", {31'b0, busy}, 32'h0);
        tick();
        chk("t4.err_pulse", {31'b0, err_illegal}, 32'h0);
        chk("t4.words",     {16'b0, words_wr}, 32'h5);

        // T5: base near top of address space, low bits forced, wrap, load ignored while busy
        base_load = 1'b1; base_addr = 16'hFFFF;
        tick(); base_load = 1'b0;
        chk("t5.base_addr",  {16'b0, imem_addr}, 32'hFFFC);
        chk("t5.base_words", {16'b0, words_wr}, 32'h0);
        imem_wready = 1'b0;
        set_req(4'd5, 5'd7, 5'd8, 5'd0, 6'h0, 26'h000BEEF);
        tick(); req_valid = 1'b0;
        chk("t5.w0_addr", {16'b0, imem_addr}, 32'hFFFC);
        chk("t5.w0_data", imem_wdata, 32'h14E8BEEF);
        base_load = 1'b1; base_addr = 16'h1230;
        tick(); base_load = 1'b0;
        chk("t5.load_ignored", {16'b0, imem_addr}, 32'hFFFC);
        set_req(4'd7, 5'd2, 5'd3, 5'd0, 6'h0, 26'h000FFFF);
        tick(); req_valid = 1'b0;
        imem_wready = 1'b1;
        tick();
        chk("t5.wrap_addr", {16'b0, imem_addr}, 32'h0);
        chk("t5.wrap_data", imem_wdata, 32'h4043FFFF);
        tick();
        chk("t5.we_off", {31'b0, imem_we}, 32'h0);
        chk("t5.words",  {16'b0, words_wr}, 32'h2);
        chk("t5.next",   {16'b0, imem_addr}, 32'h4);

        // T6: asynchronous reset during a stalled write
        imem_wready = 1'b0;
        set_req(4'd11, 5'd1, 5'd1, 5'd0, 6'h0, 26'h000FFFE);
        tick(); req_valid = 1'b0;
        chk("t6.we",    {31'b0, imem_we}, 32'h1);
        chk("t6.wdata", imem_wdata, 32'h8C21FFFE);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6.rst");
        tick();
        rst_n = 1'b1;
        imem_wready = 1'b1;
        tick();
        chk("t6.no_stale", {31'b0, imem_we}, 32'h0);
        set_req(4'd14, 5'd0, 5'd0, 5'd0, 6'h0, 26'h3FFFFFF);
        tick(); req_valid = 1'b0;
        chk("t6.jal_addr", {16'b0, imem_addr}, 32'h0);
        chk("t6.jal_data", imem_wdata, 32'hE7FFFFFF);
        tick();
        chk("t6.words", {16'b0, words_wr}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
